// File: rtl/byte_to_word_streamer_pkg.sv
// rtl/byte_to_word_streamer_pkg.sv - shared FSM states, error codes and AXI response constants
package byte_to_word_streamer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_CHECK,
      ST_NEXT,
      ST_FINISH,
      ST_FAIL
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISMATCH = 2'b01;
   localparam logic [1:0] ERR_RESP     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   localparam logic [1:0] RESP_OKAY    = 2'b00;

endpackage

// File: rtl/byte_to_word_streamer_cfg_seq_if.sv
// rtl/byte_to_word_streamer_cfg_seq_if.sv - AXI4-Lite bus bundle between the sequencer and its register slave
interface byte_to_word_streamer_cfg_seq_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   AWADDR;
   logic [2:0]          AWPROT;
   logic                AWVALID;
   logic                AWREADY;
   logic [DATA_W-1:0]   WDATA;
   logic [DATA_W/8-1:0] WSTRB;
   logic                WVALID;
   logic                WREADY;
   logic [1:0]          BRESP;
   logic                BVALID;
   logic                BREADY;
   logic [ADDR_W-1:0]   ARADDR;
   logic [2:0]          ARPROT;
   logic                ARVALID;
   logic                ARREADY;
   logic [DATA_W-1:0]   RDATA;
   logic [1:0]          RRESP;
   logic                RVALID;
   logic                RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
             ARADDR, ARPROT, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );
endinterface

// File: rtl/byte_to_word_streamer_cfg_seq.sv
// rtl/byte_to_word_streamer_cfg_seq.sv - programs four AXI4-Lite registers, reads each back and verifies it
module byte_to_word_streamer_cfg_seq
   import byte_to_word_streamer_pkg::*;
#(
   parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
   parameter logic [31:0] C_BASE_ADDR        = 32'h0,
   parameter int unsigned C_TIMEOUT          = 255
) (
   input  logic         ACLK,
   input  logic         ARESET,
   input  logic         start,
   input  logic [127:0] cfg_data,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic [1:0]   err_index,
   output logic [1:0]   err_code,
   byte_to_word_streamer_cfg_seq_if.master M_AXI
);

   localparam int unsigned TW = (C_TIMEOUT < 2) ? 1 : $clog2(C_TIMEOUT);

   state_t           state_q, state_d;
   logic [1:0]       index_q, index_d;
   logic [3:0][31:0] cfg_q, cfg_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             aw_done_q, aw_done_d;
   logic             w_done_q, w_done_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [1:0]       err_index_q, err_index_d;
   logic [1:0]       err_code_q, err_code_d;

   logic [31:0]                   cur_reg;
   logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr;
   logic                          tmo_hit, aw_hs, w_hs, wait_state;

   assign cur_reg  = cfg_q[index_q];
   assign cur_addr = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR) + C_M_AXI_ADDR_WIDTH'({index_q, 2'b00});

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= ST_IDLE;
         index_q     <= '0;
         cfg_q       <= '0;
         rdata_q     <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         tmo_q       <= '0;
         err_index_q <= '0;
         err_code_q  <= ERR_NONE;
      end else begin
         state_q     <= state_d;
         index_q     <= index_d;
         cfg_q       <= cfg_d;
         rdata_q     <= rdata_d;
         aw_done_q   <= aw_done_d;
         w_done_q    <= w_done_d;
         tmo_q       <= tmo_d;
         err_index_q <= err_index_d;
         err_code_q  <= err_code_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      index_d     = index_q;
      cfg_d       = cfg_q;
      rdata_d     = rdata_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      err_index_d = err_index_q;
      err_code_d  = err_code_q;
      tmo_hit     = (tmo_q == TW'(C_TIMEOUT - 1));
      aw_hs       = M_AXI.AWREADY && !aw_done_q;
      w_hs        = M_AXI.WREADY && !w_done_q;
      wait_state  = state_q inside {ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA};

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cfg_d       = cfg_data;
               index_d     = '0;
               err_index_d = '0;
               err_code_d  = ERR_NONE;
               state_d     = ST_WR;
            end
         end
         // Address and data channels complete independently; leave only once both have.
         ST_WR: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if (aw_done_d && w_done_d) begin
               state_d = ST_WR_RESP;
            end else if (tmo_hit) begin
               state_d     = ST_FAIL;
               err_index_d = index_q;
               err_code_d  = ERR_TIMEOUT;
            end
         end
         ST_WR_RESP: begin
            if (M_AXI.BVALID) begin
               if (M_AXI.BRESP != RESP_OKAY) begin
                  state_d     = ST_FAIL;
                  err_index_d = index_q;
                  err_code_d  = ERR_RESP;
               end else begin
                  state_d = ST_RD_ADDR;
               end
            end else if (tmo_hit) begin
               state_d     = ST_FAIL;
               err_index_d = index_q;
               err_code_d  = ERR_TIMEOUT;
            end
         end
         ST_RD_ADDR: begin
            if (M_AXI.ARREADY) begin
               state_d = ST_RD_DATA;
            end else if (tmo_hit) begin
               state_d     = ST_FAIL;
               err_index_d = index_q;
               err_code_d  = ERR_TIMEOUT;
            end
         end
         ST_RD_DATA: begin
            if (M_AXI.RVALID) begin
               rdata_d = M_AXI.RDATA[31:0];
               if (M_AXI.RRESP != RESP_OKAY) begin
                  state_d     = ST_FAIL;
                  err_index_d = index_q;
                  err_code_d  = ERR_RESP;
               end else begin
                  state_d = ST_CHECK;
               end
            end else if (tmo_hit) begin
               state_d     = ST_FAIL;
               err_index_d = index_q;
               err_code_d  = ERR_TIMEOUT;
            end
         end
         ST_CHECK: begin
            if (rdata_q != cur_reg) begin
               state_d     = ST_FAIL;
               err_index_d = index_q;
               err_code_d  = ERR_MISMATCH;
            end else begin
               state_d = ST_NEXT;
            end
         end
         ST_NEXT: begin
            if (index_q == 2'd3) begin
               state_d = ST_FINISH;
            end else begin
               index_d = index_q + 2'd1;
               state_d = ST_WR;
            end
         end
         ST_FINISH: state_d = ST_IDLE;
         ST_FAIL:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase

      if (state_d != ST_WR) begin
         aw_done_d = 1'b0;
         w_done_d  = 1'b0;
      end
      // The watchdog restarts whenever a handshake state is entered.
      tmo_d = (wait_state && (state_d == state_q)) ? tmo_q + 1'b1 : '0;
   end

   always_comb begin
      busy          = !(state_q inside {ST_IDLE, ST_FINISH, ST_FAIL});
      done          = (state_q == ST_FINISH);
      error         = (state_q == ST_FAIL);
      err_index     = err_index_q;
      err_code      = err_code_q;

      M_AXI.AWADDR  = cur_addr;
      M_AXI.AWPROT  = 3'b000;
      M_AXI.AWVALID = (state_q == ST_WR) && !aw_done_q;
      M_AXI.WDATA   = C_M_AXI_DATA_WIDTH'(cur_reg);
      M_AXI.WSTRB   = '1;
      M_AXI.WVALID  = (state_q == ST_WR) && !w_done_q;
      M_AXI.BREADY  = (state_q == ST_WR_RESP);
      M_AXI.ARADDR  = cur_addr;
      M_AXI.ARPROT  = 3'b000;
      M_AXI.ARVALID = (state_q == ST_RD_ADDR);
      M_AXI.RREADY  = (state_q == ST_RD_DATA);
   end

endmodule

// File: tb/tb_byte_to_word_streamer_cfg_seq.sv
// tb/tb_byte_to_word_streamer_cfg_seq.sv - directed vector bench for the AXI4-Lite config sequencer
module tb_byte_to_word_streamer_cfg_seq;

   logic         clk = 1'b0;
   logic         ARESET;
   logic         start;
   logic [127:0] cfg_data;
   logic         busy, done, error;
   logic [1:0]   err_index, err_code;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t_start;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   byte_to_word_streamer_cfg_seq_if #(.ADDR_W(32), .DATA_W(32)) axi ();

   byte_to_word_streamer_cfg_seq #(
      .C_M_AXI_ADDR_WIDTH(32),
      .C_M_AXI_DATA_WIDTH(32),
      .C_BASE_ADDR       (32'h0),
      .C_TIMEOUT         (16)
   ) dut (
      .ACLK     (clk),
      .ARESET   (ARESET),
      .start    (start),
      .cfg_data (cfg_data),
      .busy     (busy),
      .done     (done),
      .error    (error),
      .err_index(err_index),
      .err_code (err_code),
      .M_AXI    (axi)
   );

   // Slave knobs and observation state
   int          aw_delay = 0, w_delay = 0, bresp_bad = -1, rzero = -1;
   bit          ar_block = 1'b0;
   int          aw_cnt = 0, w_cnt = 0, last_widx = -1;
   bit          aw_pend = 0, w_pend = 0, aw_acc = 0, w_acc = 0, ar_prev = 0;
   logic [31:0] aw_addr_p, w_data_p, rd_data;
   logic [31:0] mem [4];
   logic [31:0] aw_log[$], w_log[$], ar_log[$];
   int          done_cnt = 0, err_cnt = 0, wviol = 0, awviol = 0, ar_rise_cyc = 0;

   initial begin
      axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.BVALID = 1'b0; axi.BRESP = 2'b00;
      axi.ARREADY = 1'b0; axi.RVALID = 1'b0; axi.RDATA = 32'h0; axi.RRESP = 2'b00;
      rd_data = 32'h0;
      forever begin
         @(negedge clk);
         if (aw_acc && axi.AWVALID) awviol++;
         if (w_acc && axi.WVALID) wviol++;
         aw_acc = 0;
         w_acc  = 0;
         if (axi.AWVALID) begin
            axi.AWREADY = (aw_cnt >= aw_delay);
            if (!axi.AWREADY) aw_cnt++;
         end else begin
            axi.AWREADY = 1'b0;
            aw_cnt = 0;
         end
         if (axi.WVALID) begin
            axi.WREADY = (w_cnt >= w_delay);
            if (!axi.WREADY) w_cnt++;
         end else begin
            axi.WREADY = 1'b0;
            w_cnt = 0;
         end
         if (axi.AWVALID && axi.AWREADY) begin
            aw_log.push_back(axi.AWADDR); aw_addr_p = axi.AWADDR; aw_pend = 1; aw_acc = 1;
         end
         if (axi.WVALID && axi.WREADY) begin
            w_log.push_back(axi.WDATA); w_data_p = axi.WDATA; w_pend = 1; w_acc = 1;
         end
         if (aw_pend && w_pend) begin
            mem[aw_addr_p[3:2]] = w_data_p;
            last_widx = int'(aw_addr_p[3:2]);
            aw_pend = 0;
            w_pend  = 0;
         end
         axi.BVALID  = axi.BREADY;
         axi.BRESP   = (axi.BREADY && last_widx == bresp_bad) ? 2'b10 : 2'b00;
         axi.ARREADY = axi.ARVALID && !ar_block;
         if (axi.ARVALID && !ar_prev) ar_rise_cyc = cyc;
         ar_prev = axi.ARVALID;
         if (axi.ARVALID && axi.ARREADY) begin
            ar_log.push_back(axi.ARADDR);
            rd_data = (int'(axi.ARADDR[3:2]) == rzero) ? 32'h0 : mem[axi.ARADDR[3:2]];
         end
         axi.RVALID = axi.RREADY;
         axi.RDATA  = rd_data;
         if (done) done_cnt++;
         if (error) err_cnt++;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic clear_obs();
      aw_log.delete(); w_log.delete(); ar_log.delete();
      done_cnt = 0; err_cnt = 0; wviol = 0; awviol = 0;
      aw_pend = 0; w_pend = 0;
   endtask

   task automatic run(input logic [127:0] cfg, input int repulse_at, input int budget,
                      output int dcyc, output int ecyc, output logic [1:0] eidx,
                      output logic [1:0] ecode, output logic busy1, output logic busy_end);
      bit fin;
      dcyc = -1; ecyc = -1; eidx = 2'b00; ecode = 2'b00; busy1 = 1'b0; busy_end = 1'b1; fin = 0;
      t_start  = cyc;
      cfg_data = cfg;
      start    = 1'b1;
      for (int n = 1; n <= budget && !fin; n++) begin
         @(posedge clk); #2;
         start = (n == repulse_at);
         if (cyc - t_start == 1) busy1 = busy;
         if (done) begin dcyc = cyc - t_start; fin = 1; busy_end = busy; end
         if (error) begin
            ecyc = cyc - t_start; eidx = err_index; ecode = err_code; fin = 1; busy_end = busy;
         end
      end
      start = 1'b0;
      check("run_completed_within_budget", fin, 1);
      repeat (4) @(posedge clk);
      #2;
   endtask

   typedef struct {
      string        name;
      logic [127:0] cfg;
      int           aw_delay, w_delay, bresp_bad, rzero;
      int           exp_done, exp_err, exp_eidx, exp_ecode, exp_aw, exp_ar;
   } vec_t;

   localparam int NV = 5;
   vec_t vecs [NV];

   initial begin
      int          dcyc, ecyc;
      logic [1:0]  eidx, ecode;
      logic        busy1, busy_end;
      logic [127:0] c;

      vecs[0] = '{"zero_wait",     128'hbeef0011_dead0011_abcd0001_0101ffff, 0, 0, -1, -1, 25, -1, 0, 0, 4, 4};
      vecs[1] = '{"wready_first",  128'h00000004_80000003_12345678_a5a55a5a, 3, 0, -1, -1, 37, -1, 0, 0, 4, 4};
      vecs[2] = '{"awready_first", 128'hffffffff_00000000_c001d00d_0f0ff0f0, 0, 2, -1, -1, 33, -1, 0, 0, 4, 4};
      vecs[3] = '{"rdata_zero",    128'hbeef0011_dead0011_abcd0001_0101ffff, 0, 0, -1,  2, -1, 18, 2, 1, 3, 3};
      vecs[4] = '{"bresp_slverr",  128'h00000004_80000003_12345678_a5a55a5a, 0, 0,  1, -1, -1,  9, 1, 2, 2, 1};

      ARESET = 1'b1; start = 1'b0; cfg_data = '0;
      repeat (3) @(posedge clk);
      #2;
      check("reset.busy_done_error", {busy, done, error}, 3'b000);
      check("reset.err_index_code", {err_index, err_code}, 4'h0);
      check("reset.valids", {axi.AWVALID, axi.WVALID, axi.ARVALID}, 3'b000);
      check("reset.readies", {axi.BREADY, axi.RREADY}, 2'b00);
      ARESET = 1'b0;
      @(posedge clk); #2;

      for (int v = 0; v < NV; v++) begin
         aw_delay = vecs[v].aw_delay; w_delay = vecs[v].w_delay;
         bresp_bad = vecs[v].bresp_bad; rzero = vecs[v].rzero; ar_block = 1'b0;
         c = vecs[v].cfg;
         clear_obs();
         run(c, 10, 80, dcyc, ecyc, eidx, ecode, busy1, busy_end);
         check({vecs[v].name, ".done_cycle"}, dcyc, vecs[v].exp_done);
         check({vecs[v].name, ".error_cycle"}, ecyc, vecs[v].exp_err);
         check({vecs[v].name, ".err_index"}, eidx, vecs[v].exp_eidx);
         check({vecs[v].name, ".err_code"}, ecode, vecs[v].exp_ecode);
         check({vecs[v].name, ".done_pulses"}, done_cnt, (vecs[v].exp_done >= 0) ? 1 : 0);
         check({vecs[v].name, ".error_pulses"}, err_cnt, (vecs[v].exp_err >= 0) ? 1 : 0);
         check({vecs[v].name, ".aw_count"}, aw_log.size(), vecs[v].exp_aw);
         check({vecs[v].name, ".w_count"}, w_log.size(), vecs[v].exp_aw);
         check({vecs[v].name, ".ar_count"}, ar_log.size(), vecs[v].exp_ar);
         check({vecs[v].name, ".valid_after_hs"}, wviol + awviol, 0);
         check({vecs[v].name, ".busy_cycle1"}, busy1, 1);
         check({vecs[v].name, ".busy_at_end"}, busy_end, 0);
         for (int k = 0; k < aw_log.size() && k < 4; k++) begin
            check($sformatf("%s.awaddr%0d", vecs[v].name, k), aw_log[k], 32'(4 * k));
            check($sformatf("%s.wdata%0d", vecs[v].name, k), w_log[k], c[32*k +: 32]);
         end
         for (int k = 0; k < ar_log.size() && k < 4; k++)
            check($sformatf("%s.araddr%0d", vecs[v].name, k), ar_log[k], 32'(4 * k));
      end

      // ARREADY never comes: watchdog must fire 16 cycles after ARVALID rises
      aw_delay = 0; w_delay = 0; bresp_bad = -1; rzero = -1; ar_block = 1'b1;
      clear_obs();
      run(128'h11111111_22222222_33333333_44444444, 10, 80, dcyc, ecyc, eidx, ecode, busy1, busy_end);
      check("timeout.arvalid_rise_cycle", ar_rise_cyc - t_start, 3);
      check("timeout.error_after_rise", ecyc - (ar_rise_cyc - t_start), 16);
      check("timeout.err_code", ecode, 2'b11);
      check("timeout.err_index", eidx, 2'b00);
      check("timeout.no_done", done_cnt, 0);
      check("timeout.arvalid_dropped", axi.ARVALID, 0);
      repeat (5) @(posedge clk);
      #2;
      check("timeout.err_code_held", {err_index, err_code}, 4'b0011);
      ar_block = 1'b0;

      // Reset in the middle of a write: VALIDs drop at the next edge, no pulses
      clear_obs();
      cfg_data = 128'hcafef00d_00000001_00000002_00000003;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      check("rst_mid.awvalid_in_wr", axi.AWVALID, 1);
      ARESET = 1'b1;
      @(posedge clk); #2;
      check("rst_mid.valids_dropped", {axi.AWVALID, axi.WVALID}, 2'b00);
      check("rst_mid.busy", busy, 0);
      ARESET = 1'b0;
      repeat (6) @(posedge clk);
      #2;
      check("rst_mid.no_pulses", done_cnt + err_cnt, 0);
      check("rst_mid.err_regs_cleared", {err_index, err_code}, 4'h0);
      check("rst_mid.idle_no_busy", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/byte_to_word_streamer_cfg_seq.md
BYTE_TO_WORD_STREAMER_CFG_SEQ -- requirements
Module: byte_to_word_streamer_cfg_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ports ACLK and ARESET.
REQ-002 Parameter C_M_AXI_ADDR_WIDTH, default 32: AXI4-Lite address width.
REQ-003 Parameter C_M_AXI_DATA_WIDTH, default 32: AXI4-Lite data width (only 32 supported).
REQ-004 Parameter C_BASE_ADDR, default 32'h0: streamer S00_AXI register base.
REQ-005 Parameter C_TIMEOUT, default 255: max cycles waiting on any single AXI handshake.
REQ-006 Ports SHALL be:
- ACLK in 1: clock.
- ARESET in 1: synchronous active-high reset.
- start in 1: begin a programming run.
- cfg_data in 128: register words; reg i = cfg_data[32i+31:32i].
- busy out 1: run in progress.
- done out 1: one-cycle pulse, run finished without error.
- error out 1: one-cycle pulse, run aborted.
- err_index out 2: register index at abort.
- err_code out 2: 01 readback mismatch, 10 non-OKAY response, 11 timeout.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY: write address channel.
- M_AXI_WDATA/WSTRB/WVALID/WREADY: write data channel.
- M_AXI_BRESP/BVALID/BREADY: write response channel.
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY: read address channel.
- M_AXI_RDATA/RRESP/RVALID/RREADY: read data channel.

Function
REQ-007 The FSM SHALL have states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, CHECK, NEXT, FINISH, FAIL.
REQ-008 In IDLE, start=1 SHALL latch cfg_data, set index=0, assert busy and enter WR on the next cycle; start SHALL be ignored while busy=1.
REQ-009 In WR, AWVALID and WVALID SHALL be asserted together, with AWADDR=C_BASE_ADDR+4*index, WDATA=reg[index], WSTRB=4'hF and AWPROT=3'b000.
REQ-010 Each of AWVALID and WVALID SHALL drop the cycle after its own handshake; WR SHALL exit to WR_RESP only after both handshakes, in either order or in the same cycle.
REQ-011 Once asserted, VALID signals and their payloads SHALL remain stable until READY is sampled high.
REQ-012 In WR_RESP, BREADY SHALL be 1; on BVALID, a BRESP other than 2'b00 SHALL go to FAIL with code 10, otherwise to RD_ADDR.
REQ-013 In RD_ADDR, ARVALID SHALL be asserted with ARADDR equal to the write address and ARPROT=0; on ARREADY go to RD_DATA.
REQ-014 In RD_DATA, RREADY SHALL be 1; on RVALID, RDATA SHALL be captured; RRESP other than 2'b00 SHALL go to FAIL with code 10, otherwise to CHECK.
REQ-015 In CHECK, captured data not equal to reg[index] SHALL go to FAIL with code 01, otherwise to NEXT.
REQ-016 NEXT SHALL go to FINISH if index==3; otherwise index SHALL increment and the FSM SHALL return to WR.
REQ-017 A timeout counter SHALL reset on entry to each of WR, WR_RESP, RD_ADDR and RD_DATA; reaching C_TIMEOUT cycles without completing the state SHALL go to FAIL with code 11.
REQ-018 FINISH SHALL pulse done for one cycle, deassert busy and return to IDLE.
REQ-019 FAIL SHALL pulse error for one cycle, hold err_index/err_code until the next start, deassert busy, drop all VALIDs and return to IDLE.
REQ-020 Latency for a zero-wait-state slave SHALL be 6 cycles per register (WR, WR_RESP, RD_ADDR, RD_DATA, CHECK, NEXT), so done occurs 25 cycles after start is sampled.

Reset
REQ-021 ARESET=1 SHALL force IDLE; all VALID and READY outputs, busy, done and error SHALL be 0; err_index, err_code, index and the timeout counter SHALL be 0.
REQ-022 ARESET asserted mid-run SHALL drop all VALIDs at the next clock edge, with no done or error pulse.

Structure
REQ-023 The FSM state enum, error-code constants and RESP_OKAY=2'b00 SHALL reside in a shared package, byte_to_word_streamer_pkg.
REQ-024 The block SHALL be a single module with no sub-modules.

Verification
REQ-025 Zero-wait slave, cfg = {beef0011, dead0011, abcd0001, 0101FFFF}, start -> writes and reads at 0x0, 0x4, 0x8 and 0xC in order, done at cycle 25, error never asserted.
REQ-026 Slave asserts WREADY 3 cycles before AWREADY -> single write with correct data, WVALID held no longer than its handshake, run completes.
REQ-027 Slave returns RDATA=0 for register 2 -> error pulse with err_index=2, err_code=01, no done, busy=0.
REQ-028 Slave returns BRESP=2'b10 on register 1 -> error with err_index=1, err_code=10, no read issued for register 1.
REQ-029 ARREADY held low with C_TIMEOUT=16 -> error with err_code=11 exactly 16 cycles after ARVALID rises; ARESET pulsed during WR -> AWVALID=0 next cycle, IDLE, no pulses.
